fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Front-end sequencer for the RISC-V pipeline.
- Owns the fetch PC register and drives the instruction-cache address and read-enable.
- Arbitrates next-PC between sequential (PC+4), branch/jump redirect from execute, and hold (decode hazard or icache miss).
- Generates pipe_stall and flush for the IF/ID boundary. The PC-select decision upstream only signals redirects; this block decides when they take effect.

Parameters:
RESET_PC, 32'h4000_0000, first instruction address fetched after reset
XLEN, 32, address width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-low reset (rst==0 resets)
redirect_valid  input  1  taken branch / jal / jalr resolved this cycle
redirect_target  input  XLEN  redirect address, word aligned
hazard_stall  input  1  decode hazard (e.g. jalr rs1 dependency), hold PC
icache_stall  input  1  icache miss in progress, icache_dout invalid
icache_addr  output  XLEN  read address, combinational from next-PC
icache_re  output  1  read enable
fetch_pc  output  XLEN  PC of instruction on icache_dout this cycle
fetch_valid  output  1  icache_dout holds a valid, non-squashed instruction
pipe_stall  output  1  freeze IF/ID register
flush  output  1  squash instruction currently in IF/ID

Behaviour:
- Timing: icache read is synchronous. Address presented in cycle N returns data in cycle N+1; fetch_pc is registered alongside.
- Reset (rst==0 on an edge):
  - state=BOOT, fetch_pc=RESET_PC, pending register redir_q=0.
  - Outputs while in reset: fetch_valid=0, flush=0, pipe_stall=1, icache_re=0, icache_addr=RESET_PC.
- Reset mid-operation: all in-flight redirects are discarded and PC returns to RESET_PC.
- States:
  - BOOT: icache_re=1, icache_addr=RESET_PC, pipe_stall=1, fetch_valid=0. Next state RUN; fetch_pc<=RESET_PC.
  - RUN: icache_re=1. Next-PC priority, highest first:
    1. redirect_valid: next=redirect_target, flush=1, pipe_stall=0. Redirect wins over hazard_stall in the same cycle.
    2. icache_stall: next=fetch_pc (re-present), go MISS, pipe_stall=1, fetch_valid=0.
    3. hazard_stall: next=fetch_pc, pipe_stall=1, fetch_valid stays 1.
    4. Otherwise: next=fetch_pc+4, pipe_stall=0.
    - fetch_pc<=next whenever next differs from fetch_pc.
  - MISS: pipe_stall=1, fetch_valid=0, icache_addr=fetch_pc.
    - redirect_valid while in MISS: redir_q<=redirect_target, flush=1, go PEND.
    - icache_stall deasserts: go RUN; data is valid that cycle (fetch_valid=1).
  - PEND: hold until icache_stall==0.
    - On that cycle: icache_addr=redir_q, fetch_pc<=redir_q, fetch_valid=0 (stale data), then RUN.
    - A second redirect in PEND overwrites redir_q (youngest wins).
- flush is asserted for exactly one cycle per accepted redirect. It is never asserted in BOOT.
- fetch_pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0), with no exception.
- redirect_target[1:0] is ignored and forced to 0.
- The same-cycle combination redirect_valid && icache_stall && state==RUN goes to PEND with redir_q=target.

Test Plan:
- Reset release -> BOOT for 1 cycle with icache_addr=32'h4000_0000. Then fetch_pc 4000_0000, 4000_0004, 4000_0008 on consecutive cycles, fetch_valid=1, pipe_stall=0.
- Redirect in RUN at fetch_pc=4000_0010, target 4000_0100 -> flush=1 for one cycle, icache_addr=4000_0100 that cycle. Next cycle fetch_pc=4000_0100, fetch_valid=1.
- hazard_stall held 2 cycles at fetch_pc 4000_0008 -> icache_addr=4000_0008 and pipe_stall=1 both cycles. Then advances to 4000_000C.
- icache_stall for 5 cycles, with redirect to 4000_0200 on cycle 2 -> flush one cycle, PEND. After stall drops: icache_addr=4000_0200, fetch_valid=0. Next cycle fetch_pc=4000_0200, fetch_valid=1.
- Simultaneous redirect_valid and hazard_stall -> redirect taken, flush=1, pipe_stall=0.
- rst=0 asserted during MISS with pending redirect -> next cycle fetch_pc=RESET_PC, redir_q discarded, BOOT sequence repeats.

Source files
------------

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC sequencer: next-PC arbitration, icache request, IF/ID stall/flush
module fetch_ctrl #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h4000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            hazard_stall,
    input  logic            icache_stall,
    output logic [XLEN-1:0] icache_addr,
    output logic            icache_re,
    output logic [XLEN-1:0] fetch_pc,
    output logic            fetch_valid,
    output logic            pipe_stall,
    output logic            flush
);

    typedef enum logic [1:0] {BOOT, RUN, MISS, PEND} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, pc_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pc_inc;
    logic            serve;

    assign tgt    = redirect_target & ~{{(XLEN-2){1'b0}}, 2'b11};
    assign pc_inc = fetch_pc_q + {{(XLEN-3){1'b0}}, 3'b100};
    // The cycle a miss resolves, MISS hands out its data exactly like a RUN cycle.
    assign serve  = (state_q == RUN) || ((state_q == MISS) && !icache_stall);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            redir_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= pc_d;
            redir_q    <= redir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        redir_d = redir_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, MISS: begin
                if (redirect_valid && icache_stall) begin
                    state_d = PEND;
                    redir_d = tgt;
                end else if (!serve || icache_stall) begin
                    state_d = MISS;
                end else begin
                    state_d = RUN;
                end
            end
            PEND: begin
                if (redirect_valid) redir_d = tgt;
                if (!icache_stall) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    // fetch_pc follows the presented address only when that address will be serviced.
    assign pc_d     = ((state_d == RUN) || (state_d == MISS)) ? icache_addr : fetch_pc_q;
    assign fetch_pc = fetch_pc_q;

    always_comb begin
        icache_re   = 1'b1;
        icache_addr = fetch_pc_q;
        pipe_stall  = 1'b1;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        case (state_q)
            BOOT: icache_addr = RESET_PC;
            RUN, MISS: begin
                if (serve) begin
                    if (redirect_valid) begin
                        icache_addr = tgt;
                        flush       = 1'b1;
                        pipe_stall  = 1'b0;
                    end else if (icache_stall) begin
                        icache_addr = fetch_pc_q;
                    end else if (hazard_stall) begin
                        fetch_valid = 1'b1;
                    end else begin
                        icache_addr = pc_inc;
                        pipe_stall  = 1'b0;
                        fetch_valid = 1'b1;
                    end
                end else begin
                    flush = redirect_valid;
                end
            end
            PEND: begin
                flush       = redirect_valid;
                icache_addr = redirect_valid ? tgt : redir_q;
            end
            default: icache_addr = RESET_PC;
        endcase
        if (!rst) begin
            icache_re   = 1'b0;
            icache_addr = RESET_PC;
            pipe_stall  = 1'b1;
            fetch_valid = 1'b0;
            flush       = 1'b0;
        end
    end

endmodule
